control_unit: RTL and testbench

- Multi-cycle FSM sequencer for the K&S 16-bit processor.
- Consumes the datapath's decoded instruction and registered flags, and drives every datapath and RAM control strobe.
- Sits beside the datapath in the CPU top level and closes the fetch/decode/execute loop.
- Also reports halt and a retired-instruction count for debug and test.

---
 rtl/control_unit.sv | 163 ++++++++++++++++
 tb/tb_control_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit: multi-cycle FETCH/DECODE/EXEC sequencer for the K&S 16-bit
// processor. It drives all datapath and RAM strobes from the decoded IR and
// the registered flags. It also reports halt and a retired-instruction count.

package k_and_s_pkg;

  typedef enum logic [3:0] {
    I_NOP    = 4'd0,
    I_LOAD   = 4'd1,
    I_STORE  = 4'd2,
    I_MOVE   = 4'd3,
    I_ADD    = 4'd4,
    I_SUB    = 4'd5,
    I_AND    = 4'd6,
    I_OR     = 4'd7,
    I_BRANCH = 4'd8,
    I_BZERO  = 4'd9,
    I_BNZERO = 4'd10,
    I_BNEG   = 4'd11,
    I_BNNEG  = 4'd12,
    I_BOV    = 4'd13,
    I_BNOV   = 4'd14,
    I_HALT   = 4'd15
  } decoded_instruction_type;

  // ALU operation encodings seen by the datapath.
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;
  localparam logic [1:0] ALU_SUB = 2'b11;

endpackage

module control_unit
  import k_and_s_pkg::*;
#(
  parameter int RETIRE_CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  decoded_instruction_type   decoded_instruction,
  input  logic                      zero_op,
  input  logic                      neg_op,
  input  logic                      unsigned_overflow,
  input  logic                      signed_overflow,
  output logic                      branch,
  output logic                      pc_enable,
  output logic                      ir_enable,
  output logic                      addr_sel,
  output logic                      c_sel,
  output logic [1:0]                operation,
  output logic                      write_reg_enable,
  output logic                      flags_reg_enable,
  output logic                      ram_write_enable,
  output logic                      halt,
  output logic [RETIRE_CNT_W-1:0]   retired_count
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [RETIRE_CNT_W-1:0] retired_q, retired_d;

  // State and retire-counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Next-state sequencing. HALTED is sticky until reset. Each EXEC cycle
  // retires one instruction. The counter wraps naturally.
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves a value unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    retired_d = retired_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = (decoded_instruction == I_HALT) ? S_HALTED : S_EXEC;
      S_EXEC: begin
        state_d   = S_FETCH;
        retired_d = retired_q + 1'b1;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_FETCH;
    endcase
  end

  // Strobe decode. These are Moore outputs in FETCH, DECODE and HALTED and
  // Mealy outputs in EXEC. Asserting rst masks everything in the same cycle,
  // so an aborted instruction issues no writes.
  always_comb begin
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    operation        = ALU_ADD;
    write_reg_enable = 1'b0;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    halt             = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH:  ir_enable = 1'b1;
        S_DECODE: ;
        S_HALTED: halt = 1'b1;
        S_EXEC: begin
          pc_enable = 1'b1;
          case (decoded_instruction)
            I_LOAD: begin
              addr_sel         = 1'b1;
              c_sel            = 1'b1;
              write_reg_enable = 1'b1;
            end
            I_STORE: begin
              addr_sel         = 1'b1;
              ram_write_enable = 1'b1;
            end
            I_MOVE: begin
              operation        = ALU_OR;  // a | a passes a through the ALU
              write_reg_enable = 1'b1;
            end
            I_ADD, I_SUB, I_AND, I_OR: begin
              write_reg_enable = 1'b1;
              flags_reg_enable = 1'b1;
              case (decoded_instruction)
                I_SUB:   operation = ALU_SUB;
                I_AND:   operation = ALU_AND;
                I_OR:    operation = ALU_OR;
                default: operation = ALU_ADD;
              endcase
            end
            I_BRANCH: branch = 1'b1;
            I_BZERO:  branch = zero_op;
            I_BNZERO: branch = !zero_op;
            I_BNEG:   branch = neg_op;
            I_BNNEG:  branch = !neg_op;
            I_BOV:    branch = unsigned_overflow | signed_overflow;
            I_BNOV:   branch = !(unsigned_overflow | signed_overflow);
            default:  ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign retired_count = rst ? '0 : retired_q;

endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit. It runs a table of EXEC-cycle vectors, then
// hand-written sequences for halt, mid-instruction reset and counter wrap.

module tb_control_unit;
  import k_and_s_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  decoded_instruction_type instr = I_NOP;
  logic zf = 1'b0, nf = 1'b0, uof = 1'b0, sof = 1'b0;

  logic branch, pc_enable, ir_enable, addr_sel, c_sel;
  logic [1:0] operation;
  logic write_reg_enable, flags_reg_enable, ram_write_enable, halt;
  logic [15:0] retired_count;

  // Narrow-counter instance for the wrap test. It gets its own output nets.
  logic s_branch, s_pc, s_ir, s_as, s_cs, s_wre, s_fre, s_rwe, s_halt;
  logic [1:0] s_op;
  logic [3:0] s_count;

  control_unit dut (
    .clk(clk), .rst(rst), .decoded_instruction(instr),
    .zero_op(zf), .neg_op(nf), .unsigned_overflow(uof), .signed_overflow(sof),
    .branch(branch), .pc_enable(pc_enable), .ir_enable(ir_enable),
    .addr_sel(addr_sel), .c_sel(c_sel), .operation(operation),
    .write_reg_enable(write_reg_enable), .flags_reg_enable(flags_reg_enable),
    .ram_write_enable(ram_write_enable), .halt(halt),
    .retired_count(retired_count)
  );

  control_unit #(.RETIRE_CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .decoded_instruction(instr),
    .zero_op(zf), .neg_op(nf), .unsigned_overflow(uof), .signed_overflow(sof),
    .branch(s_branch), .pc_enable(s_pc), .ir_enable(s_ir),
    .addr_sel(s_as), .c_sel(s_cs), .operation(s_op),
    .write_reg_enable(s_wre), .flags_reg_enable(s_fre),
    .ram_write_enable(s_rwe), .halt(s_halt),
    .retired_count(s_count)
  );

  always #5 clk = ~clk;

  // Output bundle: {branch, pc, ir, addr_sel, c_sel, op[1:0], wre, fre, rwe, halt}
  logic [10:0] outs;
  assign outs = {branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
                 write_reg_enable, flags_reg_enable, ram_write_enable, halt};

  function automatic logic [10:0] pack(logic br, logic pc, logic ir, logic as_,
                                       logic cs, logic [1:0] op, logic wre,
                                       logic fre, logic rwe, logic hl);
    return {br, pc, ir, as_, cs, op, wre, fre, rwe, hl};
  endfunction

  localparam logic [10:0] EXP_IDLE  = 11'b0;
  localparam logic [10:0] EXP_FETCH = 11'b00100000000;
  localparam logic [10:0] EXP_HALT  = 11'b00000000001;

  int n_checks = 0;
  int n_pass   = 0;
  int model_cnt = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    decoded_instruction_type instr;
    logic z, n, uo, so;
    logic br, as_, cs;
    logic [1:0] op;
    logic wre, fre, rwe;
  } vec_t;

  vec_t vecs[$];

  // Puts the DUT in FETCH with the counter cleared; checks outputs during reset.
  task automatic do_reset();
    rst = 1'b1;
    step();
    check("reset_outs", {21'd0, outs}, {21'd0, EXP_IDLE});
    check("reset_cnt", {16'd0, retired_count}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    model_cnt = 0;
  endtask

  // Runs one instruction from FETCH and returns in the next FETCH.
  task automatic run_instr(input vec_t v, input string tag);
    instr = v.instr;
    zf = v.z; nf = v.n; uof = v.uo; sof = v.so;
    #1;
    check({tag, "_fetch"}, {21'd0, outs}, {21'd0, EXP_FETCH});
    check({tag, "_cnt"}, {16'd0, retired_count}, model_cnt);
    step();
    check({tag, "_decode"}, {21'd0, outs}, {21'd0, EXP_IDLE});
    step();
    check({tag, "_exec"}, {21'd0, outs},
          {21'd0, pack(v.br, 1'b1, 1'b0, v.as_, v.cs, v.op, v.wre, v.fre, v.rwe, 1'b0)});
    step();
    model_cnt++;
  endtask

  function automatic vec_t mk(decoded_instruction_type i, logic z, logic n,
                              logic uo, logic so, logic br, logic as_, logic cs,
                              logic [1:0] op, logic wre, logic fre, logic rwe);
    vec_t v;
    v.instr = i; v.z = z; v.n = n; v.uo = uo; v.so = so;
    v.br = br; v.as_ = as_; v.cs = cs; v.op = op;
    v.wre = wre; v.fre = fre; v.rwe = rwe;
    return v;
  endfunction

  initial begin
    vec_t nop_v;
    nop_v = mk(I_NOP, 0,0,0,0, 0,0,0, 2'b00, 0,0,0);

    //             instr     z n uo so  br as cs op     wre fre rwe
    vecs.push_back(mk(I_ADD,    0,0,0,0,  0, 0, 0, 2'b00, 1,  1,  0));
    vecs.push_back(mk(I_SUB,    0,0,0,0,  0, 0, 0, 2'b11, 1,  1,  0));
    vecs.push_back(mk(I_AND,    0,0,0,0,  0, 0, 0, 2'b01, 1,  1,  0));
    vecs.push_back(mk(I_OR,     0,0,0,0,  0, 0, 0, 2'b10, 1,  1,  0));
    vecs.push_back(mk(I_LOAD,   0,0,0,0,  0, 1, 1, 2'b00, 1,  0,  0));
    vecs.push_back(mk(I_STORE,  0,0,0,0,  0, 1, 0, 2'b00, 0,  0,  1));
    vecs.push_back(mk(I_MOVE,   0,0,0,0,  0, 0, 0, 2'b10, 1,  0,  0));
    vecs.push_back(mk(I_BRANCH, 0,0,0,0,  1, 0, 0, 2'b00, 0,  0,  0));
    vecs.push_back(mk(I_BZERO,  1,0,0,0,  1, 0, 0, 2'b00, 0,  0,  0));
    vecs.push_back(mk(I_BZERO,  0,1,1,1,  0, 0, 0, 2'b00, 0,  0,  0));
    vecs.push_back(mk(I_BNZERO, 1,0,0,0,  0, 0, 0, 2'b00, 0,  0,  0));
    vecs.push_back(mk(I_BNZERO, 0,0,0,0,  1, 0, 0, 2'b00, 0,  0,  0));
    vecs.push_back(mk(I_BNEG,   0,1,0,0,  1, 0, 0, 2'b00, 0,  0,  0));
    vecs.push_back(mk(I_BNEG,   1,0,1,1,  0, 0, 0, 2'b00, 0,  0,  0));
    vecs.push_back(mk(I_BNNEG,  0,1,0,0,  0, 0, 0, 2'b00, 0,  0,  0));
    vecs.push_back(mk(I_BNNEG,  0,0,0,0,  1, 0, 0, 2'b00, 0,  0,  0));
    vecs.push_back(mk(I_BOV,    0,0,0,1,  1, 0, 0, 2'b00, 0,  0,  0));
    vecs.push_back(mk(I_BOV,    0,0,1,0,  1, 0, 0, 2'b00, 0,  0,  0));
    vecs.push_back(mk(I_BOV,    1,1,0,0,  0, 0, 0, 2'b00, 0,  0,  0));
    vecs.push_back(mk(I_BNOV,   0,0,0,0,  1, 0, 0, 2'b00, 0,  0,  0));
    vecs.push_back(mk(I_BNOV,   0,0,0,1,  0, 0, 0, 2'b00, 0,  0,  0));
    vecs.push_back(mk(I_NOP,    1,1,1,1,  0, 0, 0, 2'b00, 0,  0,  0));

    // Reset release, then the whole table back to back.
    do_reset();
    check("post_reset_fetch", {21'd0, outs}, {21'd0, EXP_FETCH});
    foreach (vecs[i]) run_instr(vecs[i], $sformatf("vec%0d", i));
    check("table_retired", {16'd0, retired_count}, model_cnt);

    // HALT after three NOPs: sticky, no strobes, counter frozen at 3.
    do_reset();
    for (int i = 0; i < 3; i++) run_instr(nop_v, "halt_nop");
    instr = I_HALT;
    #1;
    check("halt_fetch", {21'd0, outs}, {21'd0, EXP_FETCH});
    step();
    check("halt_decode", {21'd0, outs}, {21'd0, EXP_IDLE});
    step();
    for (int i = 0; i < 20; i++) begin
      instr = (i % 2 == 0) ? I_STORE : I_BRANCH;
      zf = 1'b1;
      #1;
      check($sformatf("halted_outs%0d", i), {21'd0, outs}, {21'd0, EXP_HALT});
      check($sformatf("halted_cnt%0d", i), {16'd0, retired_count}, 32'd3);
      step();
    end
    rst = 1'b1;
    #1;
    check("halt_rst_outs", {21'd0, outs}, {21'd0, EXP_IDLE});
    step();
    rst = 1'b0;
    #1;
    check("halt_rst_fetch", {21'd0, outs}, {21'd0, EXP_FETCH});
    check("halt_rst_cnt", {16'd0, retired_count}, 32'd0);

    // Reset during EXEC of STORE: the write strobe drops at once, restart in FETCH.
    do_reset();
    instr = I_STORE;
    step();
    step();
    check("abort_exec_store", {21'd0, outs},
          {21'd0, pack(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0)});
    rst = 1'b1;
    #1;
    check("abort_rst_outs", {21'd0, outs}, {21'd0, EXP_IDLE});
    step();
    rst = 1'b0;
    #1;
    check("abort_fetch", {21'd0, outs}, {21'd0, EXP_FETCH});
    check("abort_cnt", {16'd0, retired_count}, 32'd0);

    // 17 NOPs: the 4-bit counter wraps to 1, the 16-bit counter reads 17.
    do_reset();
    for (int i = 0; i < 17; i++) run_instr(nop_v, "wrap_nop");
    check("wrap_cnt4", {28'd0, s_count}, 32'd1);
    check("wrap_cnt16", {16'd0, retired_count}, 32'd17);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
